// File: rtl/lc3b_types.sv
// Shared LC-3b widths and the data-memory opcode set used by the MEM stage.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam lc3b_opcode op_ldb = 4'b0010;
  localparam lc3b_opcode op_ldw = 4'b0110;
  localparam lc3b_opcode op_ldi = 4'b1010;
  localparam lc3b_opcode op_stb = 4'b0011;
  localparam lc3b_opcode op_stw = 4'b0111;
  localparam lc3b_opcode op_sti = 4'b1011;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return (op == op_ldb) || (op == op_ldw) || (op == op_ldi) ||
           (op == op_stb) || (op == op_stw) || (op == op_sti);
  endfunction

  function automatic logic is_store_op(input lc3b_opcode op);
    return (op == op_stb) || (op == op_stw) || (op == op_sti);
  endfunction

  function automatic logic is_ind_op(input lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

  function automatic logic is_byte_op(input lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store lane mask/replication and LDB byte select with sign extension.
module mem_lane_align
  import lc3b_types::*;
(
  input  lc3b_opcode    opcode,
  input  logic          addr_lsb,
  input  lc3b_word      wdata,
  input  lc3b_word      rdata,
  output lc3b_mem_wmask byte_enable,
  output lc3b_word      wdata_aligned,
  output lc3b_word      rdata_ext
);

  logic [7:0] rbyte;

  always_comb begin
    byte_enable   = 2'b11;
    wdata_aligned = wdata;
    rdata_ext     = rdata;
    rbyte         = addr_lsb ? rdata[15:8] : rdata[7:0];
    if (opcode == op_stb) begin
      byte_enable   = addr_lsb ? 2'b10 : 2'b01;
      wdata_aligned = {wdata[7:0], wdata[7:0]};
    end
    if (opcode == op_ldb) begin
      rdata_ext = {{8{rbyte[7]}}, rbyte};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM stage: runs data-memory transactions (incl. two-phase LDI/STI) and fills MEM/WB.
module mem_stage_ctrl
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ex_mem_valid,
  input  lc3b_opcode    ex_mem_opcode,
  input  lc3b_word      ex_mem_address,
  input  lc3b_word      ex_mem_wdata,
  input  lc3b_word      ex_mem_alu_result,
  input  lc3b_reg       ex_mem_dr_out,
  input  logic          ex_mem_load_regfile,
  output logic          dmem_read,
  output logic          dmem_write,
  output lc3b_word      dmem_address,
  output lc3b_word      dmem_wdata,
  output lc3b_mem_wmask dmem_byte_enable,
  input  logic          dmem_resp,
  input  lc3b_word      dmem_rdata,
  output logic          mem_stall,
  output logic          mem_wb_valid,
  output logic          mem_wb_load_regfile,
  output lc3b_reg       mem_wb_dr_out,
  output lc3b_word      mem_wb_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StIndAddr, StIndData} state_e;

  state_e        state_q, state_d;
  lc3b_word      ptr_q, ptr_d;
  logic          is_mem, is_store, is_ind, is_byte;
  logic          stall_raw, complete;
  lc3b_mem_wmask lane_be;
  lc3b_word      lane_wdata, lane_rdata;

  assign is_mem   = ex_mem_valid && is_mem_op(ex_mem_opcode);
  assign is_store = is_store_op(ex_mem_opcode);
  assign is_ind   = is_ind_op(ex_mem_opcode);
  assign is_byte  = is_byte_op(ex_mem_opcode);
  assign complete = dmem_resp && ((state_q == StAccess) || (state_q == StIndData));
  // The IDLE-cycle stall is decoded from ex_mem inputs, so it must be masked during reset.
  assign mem_stall = stall_raw && reset_n;

  mem_lane_align u_lane (
    .opcode        (ex_mem_opcode),
    .addr_lsb      (ex_mem_address[0]),
    .wdata         (ex_mem_wdata),
    .rdata         (dmem_rdata),
    .byte_enable   (lane_be),
    .wdata_aligned (lane_wdata),
    .rdata_ext     (lane_rdata)
  );

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = '0;
    stall_raw        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          stall_raw = 1'b1;
          state_d   = is_ind ? StIndAddr : StAccess;
        end
      end
      StAccess: begin
        dmem_read        = !is_store;
        dmem_write       = is_store;
        dmem_address     = is_byte ? ex_mem_address : {ex_mem_address[15:1], 1'b0};
        dmem_wdata       = lane_wdata;
        dmem_byte_enable = lane_be;
        stall_raw        = !dmem_resp;
        if (dmem_resp) state_d = StIdle;
      end
      StIndAddr: begin
        dmem_read        = 1'b1;
        dmem_address     = {ex_mem_address[15:1], 1'b0};
        dmem_byte_enable = 2'b11;
        stall_raw        = 1'b1;
        if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          state_d = StIndData;
        end
      end
      StIndData: begin
        dmem_read        = !is_store;
        dmem_write       = is_store;
        dmem_address     = {ptr_q[15:1], 1'b0};
        dmem_wdata       = ex_mem_wdata;
        dmem_byte_enable = 2'b11;
        stall_raw        = !dmem_resp;
        if (dmem_resp) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Stalled edges insert bubbles so forwarding never sees a half-finished entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wb_valid        <= 1'b0;
      mem_wb_load_regfile <= 1'b0;
      mem_wb_dr_out       <= '0;
      mem_wb_data         <= '0;
    end else if (mem_stall) begin
      mem_wb_valid        <= 1'b0;
      mem_wb_load_regfile <= 1'b0;
    end else if (complete) begin
      mem_wb_valid        <= 1'b1;
      mem_wb_load_regfile <= is_store ? 1'b0 : ex_mem_load_regfile;
      mem_wb_dr_out       <= ex_mem_dr_out;
      mem_wb_data         <= is_store ? '0 : lane_rdata;
    end else begin
      mem_wb_valid        <= ex_mem_valid;
      mem_wb_load_regfile <= ex_mem_valid && ex_mem_load_regfile;
      mem_wb_dr_out       <= ex_mem_dr_out;
      mem_wb_data         <= ex_mem_alu_result;
    end
  end

endmodule
